// File: rtl/pulse_rate_divider.sv
// pulse_rate_divider: programmable-period one-cycle tick generator with run/pause and single-step.
// Define PULSE_RATE_DIVIDER_TICKCNT_EN to add the tick_total counter and its tick_clr input.
module pulse_rate_divider #(
   parameter int CNT_W = 26,
   parameter int unsigned DEFAULT_PERIOD = 50000000
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             enable,
   input  logic             step_req,
   input  logic [CNT_W-1:0] period_in,
   input  logic             period_load,
   output logic             tick_out,
   output logic             running,
   output logic [CNT_W-1:0] cur_count
`ifdef PULSE_RATE_DIVIDER_TICKCNT_EN
   ,
   input  logic             tick_clr,
   output logic [7:0]       tick_total
`endif
);
   localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_PERIOD);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP} state_t;

   state_t state, state_nx;
   logic [CNT_W-1:0] period_reg, pend_reg, count, period_nx, pend_nx, count_nx, src;
   logic pend_valid, pend_valid_nx, step_q, tick_nx, reload;

   function automatic logic [CNT_W-1:0] eff_m1(input logic [CNT_W-1:0] p);
      return (p == '0) ? '0 : p - 1'b1;
   endfunction

   assign cur_count = count;
   // A same-cycle load beats a pending one, which beats the current period.
   assign src    = period_load ? period_in : (pend_valid ? pend_reg : period_reg);
   assign reload = (state == S_STEP) || (state == S_RUN && enable && count == '0);

   always_comb begin
      state_nx      = state;
      count_nx      = count;
      period_nx     = period_reg;
      pend_nx       = pend_reg;
      pend_valid_nx = pend_valid;
      tick_nx       = 1'b0;
      case (state)
         S_IDLE: begin
            if (period_load) begin
               period_nx     = period_in;
               count_nx      = eff_m1(period_in);
               pend_valid_nx = 1'b0;
            end
            state_nx = enable ? S_RUN : ((step_req && !step_q) ? S_STEP : S_IDLE);
         end
         S_RUN: begin
            if (period_load) begin
               pend_nx       = period_in;
               pend_valid_nx = 1'b1;
            end
            if (!enable) state_nx = S_IDLE;
            else if (count != '0) count_nx = count - 1'b1;
         end
         S_STEP:  state_nx = enable ? S_RUN : S_IDLE;
         default: state_nx = S_IDLE;
      endcase
      if (reload) begin
         tick_nx       = 1'b1;
         period_nx     = src;
         count_nx      = eff_m1(src);
         pend_valid_nx = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= S_IDLE;
         period_reg <= DEF;
         pend_reg   <= DEF;
         pend_valid <= 1'b0;
         count      <= DEF - 1'b1;
         step_q     <= 1'b0;
         tick_out   <= 1'b0;
         running    <= 1'b0;
      end else begin
         state      <= state_nx;
         period_reg <= period_nx;
         pend_reg   <= pend_nx;
         pend_valid <= pend_valid_nx;
         count      <= count_nx;
         step_q     <= step_req;
         tick_out   <= tick_nx;
         running    <= (state_nx == S_RUN);
      end
   end

`ifdef PULSE_RATE_DIVIDER_TICKCNT_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) tick_total <= '0;
      else tick_total <= tick_clr ? 8'd0 : tick_total + {7'd0, tick_out};
   end
`endif
endmodule

// File: tb/tb_pulse_rate_divider.sv
// tb_pulse_rate_divider: directed checks of pulse_rate_divider with DEFAULT_PERIOD=4.
// Covers tick counter checks when PULSE_RATE_DIVIDER_TICKCNT_EN is defined.
module tb_pulse_rate_divider;
   localparam int W = 8;

   logic clk = 1'b0, resetn = 1'b0, enable = 1'b0, step_req = 1'b0, period_load = 1'b0;
   logic [W-1:0] period_in = '0;
   logic tick_out, running;
   logic [W-1:0] cur_count;
   int checks = 0, errors = 0;
`ifdef PULSE_RATE_DIVIDER_TICKCNT_EN
   logic tick_clr = 1'b0;
   logic [7:0] tick_total;
`endif

   pulse_rate_divider #(.CNT_W(W), .DEFAULT_PERIOD(4)) dut (
      .clk(clk), .resetn(resetn), .enable(enable), .step_req(step_req),
      .period_in(period_in), .period_load(period_load),
      .tick_out(tick_out), .running(running), .cur_count(cur_count)
`ifdef PULSE_RATE_DIVIDER_TICKCNT_EN
      , .tick_clr(tick_clr), .tick_total(tick_total)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Cycles until the next tick; -1 if none within the bound.
   task automatic wait_tick(output int n);
      int i;
      n = -1;
      i = 0;
      while (n < 0 && i < 100) begin
         cyc(1);
         i++;
         if (tick_out) n = i;
      end
   endtask

   task automatic idle_load(input int p);
      enable = 1'b0;
      cyc(1);
      period_in = W'(p);
      period_load = 1'b1;
      cyc(1);
      period_load = 1'b0;
   endtask

   initial begin
      int n, cnt;
      cyc(2);
      chk("rst_tick", tick_out, 0);
      chk("rst_running", running, 0);
      chk("rst_count", cur_count, 3);
`ifdef PULSE_RATE_DIVIDER_TICKCNT_EN
      chk("rst_total", tick_total, 0);
`endif
      resetn = 1'b1;
      enable = 1'b1;
      cyc(1);
      chk("run_running", running, 1);
      wait_tick(n); chk("run_first", n, 4);
      wait_tick(n); chk("run_gap1", n, 4);
      wait_tick(n); chk("run_gap2", n, 4);

      idle_load(0);
      chk("p0_count", cur_count, 0);
      enable = 1'b1;
      cyc(1);
      wait_tick(n); chk("p0_first", n, 1);
      for (int i = 0; i < 4; i++) begin cyc(1); chk("p0_every", tick_out, 1); end
      idle_load(1);
      chk("p1_count", cur_count, 0);
      enable = 1'b1;
      cyc(1);
      wait_tick(n); chk("p1_first", n, 1);
      for (int i = 0; i < 3; i++) begin cyc(1); chk("p1_every", tick_out, 1); end

      idle_load(8);
      enable = 1'b1;
      cyc(1);
      wait_tick(n); chk("p8_first", n, 8);
      cyc(4);
      chk("p8_at3", cur_count, 3);
      period_in = 8'd3;
      period_load = 1'b1;
      cyc(1);
      period_load = 1'b0;
      wait_tick(n); chk("p8_finish", n + 5, 8);
      wait_tick(n); chk("p3_gap1", n, 3);
      wait_tick(n); chk("p3_gap2", n, 3);

      idle_load(6);
      chk("pause_count", cur_count, 5);
      cnt = 0;
      for (int i = 0; i < 3; i++) begin
         step_req = 1'b1; cyc(1); cnt += int'(tick_out);
         step_req = 1'b0; cyc(1); cnt += int'(tick_out);
         cyc(1); cnt += int'(tick_out);
      end
      chk("step_three", cnt, 3);
      chk("step_count", cur_count, 5);
      cnt = 0;
      step_req = 1'b1;
      for (int i = 0; i < 10; i++) begin cyc(1); cnt += int'(tick_out); end
      step_req = 1'b0;
      for (int i = 0; i < 2; i++) begin cyc(1); cnt += int'(tick_out); end
      chk("step_held", cnt, 1);

      enable = 1'b1;
      cyc(1);
      wait_tick(n); chk("p6_first", n, 6);
      cyc(3);
      chk("p6_at2", cur_count, 2);
      enable = 1'b0;
      cyc(1);
      chk("pause_running", running, 0);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin cyc(1); cnt += int'(tick_out); end
      chk("pause_noticks", cnt, 0);
      chk("pause_hold", cur_count, 2);
      enable = 1'b1;
      cyc(1);
      chk("resume_running", running, 1);
      wait_tick(n); chk("resume_first", n, 3);
      wait_tick(n); chk("resume_gap", n, 6);

      period_in = 8'd2;
      period_load = 1'b1;
      cyc(1);
      period_load = 1'b0;
      wait_tick(n); chk("pend_finish", n, 5);
      resetn = 1'b0;
      #1;
      chk("arst_tick", tick_out, 0);
      chk("arst_running", running, 0);
      chk("arst_count", cur_count, 3);
      cyc(1);
      resetn = 1'b1;
      cyc(1);
      wait_tick(n); chk("arst_first", n, 4);
      wait_tick(n); chk("arst_gap", n, 4);

`ifdef PULSE_RATE_DIVIDER_TICKCNT_EN
      idle_load(1);
      tick_clr = 1'b1;
      cyc(1);
      tick_clr = 1'b0;
      chk("tc_clear", tick_total, 0);
      enable = 1'b1;
      cyc(1);
      cyc(260);
      enable = 1'b0;
      cyc(2);
      chk("tc_wrap", tick_total, 4);
      enable = 1'b1;
      cyc(2);
      chk("tc_ontick", tick_out, 1);
      tick_clr = 1'b1;
      cyc(1);
      tick_clr = 1'b0;
      chk("tc_clr_tick", tick_total, 0);
      enable = 1'b0;
      cyc(2);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
